// File: rtl/div_sched_pkg.sv
// Shared state encoding and divider handshake constants for the divider issue scheduler.
package div_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_START  = 4'b0010,
        S_BUSY   = 4'b0100,
        S_RESULT = 4'b1000
    } sched_state_e;

    // One-hot state reported by the shared iterative divider.
    localparam logic [2:0] DIV_INITIAL = 3'b001;
    localparam logic [2:0] DIV_COMPUTE = 3'b010;
    localparam logic [2:0] DIV_DONE    = 3'b100;

    // Quotient reported for a trapped divide-by-zero, sliced to DATA_W by the user.
    localparam logic [31:0] DIV_Q_DIVZERO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first pending request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int  cand;
        logic found;
        cand      = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
        grant_valid = found;
    end

endmodule

// File: rtl/div_issue_scheduler.sv
// Shares one iterative divider among NUM_REQ requesters and returns results toward the CDB.
// Define DIV_ZERO_TRAP_EN to answer y==0 requests locally instead of issuing them.
module div_issue_scheduler
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TAG_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      flush,
    output logic [DATA_W-1:0]         div_xin,
    output logic [DATA_W-1:0]         div_yin,
    output logic [TAG_W-1:0]          div_tag_in,
    output logic                      div_start,
    output logic                      div_ack,
    input  logic [2:0]                div_state,
    input  logic [DATA_W-1:0]         div_quotient,
    input  logic [DATA_W-1:0]         div_remainder,
    input  logic [TAG_W-1:0]          div_tag_out,
    output logic                      cdb_valid,
    input  logic                      cdb_ready,
    output logic [DATA_W-1:0]         cdb_q,
    output logic [DATA_W-1:0]         cdb_r,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic                      cdb_err,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e      state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] op_x_q, op_x_d;
    logic [DATA_W-1:0] op_y_q, op_y_d;
    logic [TAG_W-1:0]  op_tag_q, op_tag_d;
    logic              killed_q, killed_d;
    logic [DATA_W-1:0] cdb_q_q, cdb_q_d;
    logic [DATA_W-1:0] cdb_r_q, cdb_r_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
`ifdef DIV_ZERO_TRAP_EN
    logic              cdb_err_q, cdb_err_d;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [DATA_W-1:0]  sel_x, sel_y;
    logic [TAG_W-1:0]   sel_tag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign sel_x   = req_x[grant_idx*DATA_W +: DATA_W];
    assign sel_y   = req_y[grant_idx*DATA_W +: DATA_W];
    assign sel_tag = req_tag[grant_idx*TAG_W +: TAG_W];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        op_x_d    = op_x_q;
        op_y_d    = op_y_q;
        op_tag_d  = op_tag_q;
        killed_d  = killed_q;
        cdb_q_d   = cdb_q_q;
        cdb_r_d   = cdb_r_q;
        cdb_tag_d = cdb_tag_q;
`ifdef DIV_ZERO_TRAP_EN
        cdb_err_d = cdb_err_q;
`endif
        req_ready = '0;
        div_start = 1'b0;
        div_ack   = 1'b0;

        case (state_q)
            S_IDLE: begin
                killed_d = 1'b0;
                if (!flush && grant_valid) begin
                    req_ready = grant;
                    op_x_d    = sel_x;
                    op_y_d    = sel_y;
                    op_tag_d  = sel_tag;
                    ptr_d     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                    if (sel_y == '0) begin
                        cdb_q_d   = DIV_Q_DIVZERO[DATA_W-1:0];
                        cdb_r_d   = sel_x;
                        cdb_tag_d = sel_tag;
                        cdb_err_d = 1'b1;
                        state_d   = S_RESULT;
                    end else begin
                        state_d = S_START;
                    end
`else
                    state_d = S_START;
`endif
                end
            end

            // A flush here still lets the divider run to DONE so it can be Acked back to INITIAL.
            S_START: begin
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (div_state == DIV_INITIAL) begin
                    div_start = 1'b1;
                    state_d   = S_BUSY;
                end
            end

            S_BUSY: begin
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (div_state == DIV_DONE) begin
                    div_ack = 1'b1;
                    if (killed_q || flush) begin
                        killed_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        cdb_q_d   = div_quotient;
                        cdb_r_d   = div_remainder;
                        cdb_tag_d = div_tag_out;
`ifdef DIV_ZERO_TRAP_EN
                        cdb_err_d = 1'b0;
`endif
                        state_d   = S_RESULT;
                    end
                end
            end

            S_RESULT: begin
                if (flush || cdb_ready) begin
                    killed_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                killed_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            op_x_q    <= '0;
            op_y_q    <= '0;
            op_tag_q  <= '0;
            killed_q  <= 1'b0;
            cdb_q_q   <= '0;
            cdb_r_q   <= '0;
            cdb_tag_q <= '0;
`ifdef DIV_ZERO_TRAP_EN
            cdb_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            op_x_q    <= op_x_d;
            op_y_q    <= op_y_d;
            op_tag_q  <= op_tag_d;
            killed_q  <= killed_d;
            cdb_q_q   <= cdb_q_d;
            cdb_r_q   <= cdb_r_d;
            cdb_tag_q <= cdb_tag_d;
`ifdef DIV_ZERO_TRAP_EN
            cdb_err_q <= cdb_err_d;
`endif
        end
    end

    assign div_xin    = op_x_q;
    assign div_yin    = op_y_q;
    assign div_tag_in = op_tag_q;
    assign cdb_valid  = (state_q == S_RESULT);
    assign cdb_q      = cdb_q_q;
    assign cdb_r      = cdb_r_q;
    assign cdb_tag    = cdb_tag_q;
    assign busy       = (state_q != S_IDLE);
`ifdef DIV_ZERO_TRAP_EN
    assign cdb_err    = cdb_err_q;
`else
    assign cdb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_scheduler.sv
// Directed bench for div_issue_scheduler with a behavioural model of the shared divider.
module tb_div_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_x, req_y;
    logic [11:0] req_tag;
    logic [3:0]  req_ready;
    logic        flush;
    logic [7:0]  div_xin, div_yin;
    logic [2:0]  div_tag_in;
    logic        div_start, div_ack;
    logic [2:0]  div_state;
    logic [7:0]  div_quotient, div_remainder;
    logic [2:0]  div_tag_out;
    logic        cdb_valid, cdb_ready;
    logic [7:0]  cdb_q, cdb_r;
    logic [2:0]  cdb_tag;
    logic        cdb_err, busy;

    logic [7:0]  dv_x, dv_y;
    int          cyc = 0;
    int          viol = 0;
    int          start_count = 0;
    int          passCount = 0;
    int          checkCount = 0;

    logic [7:0]  tx [4] = '{8'd20, 8'd15, 8'd9, 8'd7};
    logic [7:0]  ty [4] = '{8'd6, 8'd4, 8'd9, 8'd8};
    logic [2:0]  ttag [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0]  tq [4] = '{8'd3, 8'd3, 8'd1, 8'd0};
    logic [7:0]  tr [4] = '{8'd2, 8'd3, 8'd0, 8'd7};

    div_issue_scheduler #(.NUM_REQ(4), .DATA_W(8), .TAG_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_tag       (req_tag),
        .req_ready     (req_ready),
        .flush         (flush),
        .div_xin       (div_xin),
        .div_yin       (div_yin),
        .div_tag_in    (div_tag_in),
        .div_start     (div_start),
        .div_ack       (div_ack),
        .div_state     (div_state),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_tag_out   (div_tag_out),
        .cdb_valid     (cdb_valid),
        .cdb_ready     (cdb_ready),
        .cdb_q         (cdb_q),
        .cdb_r         (cdb_r),
        .cdb_tag       (cdb_tag),
        .cdb_err       (cdb_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Repeated-subtraction divider: one quotient step per COMPUTE cycle, DONE holds until Ack.
    always @(posedge clk) begin
        if (reset) begin
            div_state    <= 3'b001;
            dv_x         <= '0;
            dv_y         <= '0;
            div_quotient <= '0;
            div_tag_out  <= '0;
        end else begin
            case (div_state)
                3'b001: if (div_start) begin
                    dv_x         <= div_xin;
                    dv_y         <= div_yin;
                    div_tag_out  <= div_tag_in;
                    div_quotient <= '0;
                    div_state    <= 3'b010;
                end
                3'b010: if (dv_x >= dv_y) begin
                    dv_x         <= dv_x - dv_y;
                    div_quotient <= div_quotient + 8'd1;
                end else begin
                    div_state <= 3'b100;
                end
                3'b100: if (div_ack) div_state <= 3'b001;
                default: div_state <= 3'b001;
            endcase
        end
    end
    assign div_remainder = dv_x;

    always @(negedge clk) begin
        if (!reset) begin
            if (div_start && div_state != 3'b001) viol++;
            if (div_ack && div_state != 3'b100) viol++;
            if ($countones(req_ready) > 1) viol++;
        end
        if (div_start) start_count++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int port, input logic [7:0] x, input logic [7:0] y, input logic [2:0] tag);
        req_x[port*8 +: 8]   = x;
        req_y[port*8 +: 8]   = y;
        req_tag[port*3 +: 3] = tag;
        req_valid[port]      = 1'b1;
    endtask

    task automatic driveEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic waitGrant(input string name, input logic [3:0] expected);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 4'b0 && n < 400);
        checkOutput(name, {28'b0, req_ready}, {28'b0, expected});
    endtask

    task automatic waitResult(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cdb_valid && n < 400);
        checkOutput(name, {31'b0, cdb_valid}, 32'd1);
    endtask

    task automatic checkResult(input string name, input logic [7:0] q, input logic [7:0] r, input logic [2:0] tag);
        checkOutput({name, "_q"}, {24'b0, cdb_q}, {24'b0, q});
        checkOutput({name, "_r"}, {24'b0, cdb_r}, {24'b0, r});
        checkOutput({name, "_tag"}, {29'b0, cdb_tag}, {29'b0, tag});
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_req_ready"}, {28'b0, req_ready}, 32'd0);
        checkOutput({name, "_div_start"}, {31'b0, div_start}, 32'd0);
        checkOutput({name, "_div_ack"}, {31'b0, div_ack}, 32'd0);
        checkOutput({name, "_cdb_valid"}, {31'b0, cdb_valid}, 32'd0);
        checkOutput({name, "_cdb_q"}, {24'b0, cdb_q}, 32'd0);
        checkOutput({name, "_cdb_r"}, {24'b0, cdb_r}, 32'd0);
        checkOutput({name, "_cdb_tag"}, {29'b0, cdb_tag}, 32'd0);
        checkOutput({name, "_cdb_err"}, {31'b0, cdb_err}, 32'd0);
        checkOutput({name, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          t0;
        int          s0;
        logic        saw_valid;
        logic [3:0]  exp_g;
        int          idx;

        reset     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_tag   = '0;
        flush     = 1'b0;
        cdb_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        driveEdge();
        reset = 1'b0;

        // All four requesters pending: grants rotate 0,1,2,3,0.
        driveEdge();
        for (int i = 0; i < 4; i++) applyStimulus(i, tx[i], ty[i], ttag[i]);
        cdb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idx   = k % 4;
            exp_g = 4'b0001 << idx;
            waitGrant($sformatf("rr_grant%0d", k), exp_g);
            if (k == 4) begin
                driveEdge();
                req_valid = '0;
            end
            waitResult($sformatf("rr_valid%0d", k));
            checkResult($sformatf("rr_res%0d", k), tq[idx], tr[idx], ttag[idx]);
        end

        // Single request on port 2: 100/7 = 14 r 2, result valid 18 cycles after grant.
        driveEdge();
        applyStimulus(2, 8'd100, 8'd7, 3'd5);
        t0 = cyc;
        @(negedge clk);
        checkOutput("single_grant", {28'b0, req_ready}, 32'h4);
        driveEdge();
        req_valid = '0;
        @(negedge clk);
        checkOutput("single_start", {31'b0, div_start}, 32'd1);
        waitResult("single_valid");
        checkOutput("single_latency", cyc - t0, 32'd18);
        checkResult("single_res", 8'd14, 8'd2, 3'd5);
        checkOutput("single_err", {31'b0, cdb_err}, 32'd0);
        @(negedge clk);
        checkOutput("single_accepted", {31'b0, cdb_valid}, 32'd0);
        checkOutput("single_idle", {31'b0, busy}, 32'd0);

        // Result held while the CDB stalls; a pending request must wait.
        driveEdge();
        cdb_ready = 1'b0;
        applyStimulus(1, 8'd30, 8'd10, 3'd6);
        waitGrant("stall_grant", 4'b0010);
        driveEdge();
        req_valid = '0;
        applyStimulus(3, 8'd50, 8'd25, 3'd7);
        waitResult("stall_valid");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_valid_c%0d", c), {31'b0, cdb_valid}, 32'd1);
            checkResult($sformatf("stall_res_c%0d", c), 8'd3, 8'd0, 3'd6);
            checkOutput($sformatf("stall_nogrant_c%0d", c), {28'b0, req_ready}, 32'd0);
            checkOutput($sformatf("stall_divinit_c%0d", c), {29'b0, div_state}, 32'd1);
        end
        driveEdge();
        cdb_ready = 1'b1;
        waitGrant("stall_next_grant", 4'b1000);
        driveEdge();
        req_valid = '0;
        waitResult("stall_next_valid");
        checkResult("stall_next_res", 8'd2, 8'd0, 3'd7);

        // Flush while busy: divider is Acked, no result appears.
        driveEdge();
        applyStimulus(0, 8'd200, 8'd1, 3'd2);
        waitGrant("flush_grant", 4'b0001);
        driveEdge();
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        driveEdge();
        flush = 1'b0;
        saw_valid = 1'b0;
        for (int n = 0; n < 400 && !div_ack; n++) begin
            @(negedge clk);
            saw_valid = saw_valid | cdb_valid;
        end
        checkOutput("flush_ack", {31'b0, div_ack}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            saw_valid = saw_valid | cdb_valid;
        end
        checkOutput("flush_no_valid", {31'b0, saw_valid}, 32'd0);
        checkOutput("flush_idle", {31'b0, busy}, 32'd0);
        checkOutput("flush_div_init", {29'b0, div_state}, 32'd1);
        driveEdge();
        applyStimulus(1, 8'd17, 8'd5, 3'd3);
        waitGrant("flush_next_grant", 4'b0010);
        driveEdge();
        req_valid = '0;
        waitResult("flush_next_valid");
        checkResult("flush_next_res", 8'd3, 8'd2, 3'd3);

        // Flush (together with cdb_ready) in the result state drops the result.
        driveEdge();
        cdb_ready = 1'b0;
        applyStimulus(2, 8'd6, 8'd3, 3'd1);
        waitGrant("rflush_grant", 4'b0100);
        driveEdge();
        req_valid = '0;
        waitResult("rflush_valid");
        checkOutput("rflush_q", {24'b0, cdb_q}, 32'd2);
        driveEdge();
        flush     = 1'b1;
        cdb_ready = 1'b1;
        driveEdge();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("rflush_dropped", {31'b0, cdb_valid}, 32'd0);
        checkOutput("rflush_idle", {31'b0, busy}, 32'd0);

        // Reset mid-operation restores reset values and the pointer.
        driveEdge();
        applyStimulus(1, 8'd100, 8'd1, 3'd5);
        waitGrant("rst_grant", 4'b0010);
        driveEdge();
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        driveEdge();
        @(negedge clk);
        checkResetOutputs("midreset");
        checkOutput("midreset_div_init", {29'b0, div_state}, 32'd1);
        driveEdge();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(i, tx[i], ty[i], ttag[i]);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_blocks_grant", {28'b0, req_ready}, 32'd0);
        driveEdge();
        flush = 1'b0;
        waitGrant("rst_ptr_zero", 4'b0001);
        driveEdge();
        req_valid = '0;
        waitResult("rst_after_valid");
        checkResult("rst_after_res", tq[0], tr[0], ttag[0]);

`ifdef DIV_ZERO_TRAP_EN
        // Divide-by-zero is answered without touching the divider.
        driveEdge();
        s0 = start_count;
        applyStimulus(1, 8'd9, 8'd0, 3'd4);
        t0 = cyc;
        waitGrant("dz_grant", 4'b0010);
        driveEdge();
        req_valid = '0;
        waitResult("dz_valid");
        checkOutput("dz_latency", cyc - t0, 32'd1);
        checkResult("dz_res", 8'hFF, 8'd9, 3'd4);
        checkOutput("dz_err", {31'b0, cdb_err}, 32'd1);
        checkOutput("dz_no_start", start_count - s0, 32'd0);
        @(negedge clk);
`else
        s0 = start_count;
`endif

        checkOutput("protocol_violations", viol, 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
